// File: rtl/alarm_pkg.sv
// alarm_pkg: shared constants for the alarm_bank slice.
//   Cursor one-hot codes (MT..SU), blinky codes, FSM state enum,
//   BCD digit limits and a cursor->blinky helper.
package alarm_pkg;

    localparam int TENS_MAX  = 5;
    localparam int UNITS_MAX = 9;

    localparam logic [3:0] CUR_NONE = 4'b0000;
    localparam logic [3:0] CUR_MT   = 4'b1000;
    localparam logic [3:0] CUR_MU   = 4'b0100;
    localparam logic [3:0] CUR_ST   = 4'b0010;
    localparam logic [3:0] CUR_SU   = 4'b0001;

    localparam logic [2:0] BLK_NONE = 3'b000;
    localparam logic [2:0] BLK_MT   = 3'b001;
    localparam logic [2:0] BLK_MU   = 3'b010;
    localparam logic [2:0] BLK_ST   = 3'b011;
    localparam logic [2:0] BLK_SU   = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EDIT   = 2'd1,
        ST_RING   = 2'd2,
        ST_SNOOZE = 2'd3
    } state_t;

    function automatic logic [2:0] blinky_of(input logic [3:0] cur);
        logic [2:0] b;
        b = BLK_NONE;
        case (cur)
            CUR_MT:  b = BLK_MT;
            CUR_MU:  b = BLK_MU;
            CUR_ST:  b = BLK_ST;
            CUR_SU:  b = BLK_SU;
            default: b = BLK_NONE;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/alarm_bank_digit.sv
// bcd_wrap_digit: one BCD digit of the edit working copy.
//   Wraps MAX->0 on inc and 0->MAX on dec; inc+dec together holds.
//   load has priority over inc/dec.
// Ports:
//   clk4, reset       clock, async active-high reset
//   i_load/i_load_val load the digit from the selected slot
//   i_inc/i_dec       single-cycle step pulses
//   o_digit           registered digit value
module bcd_wrap_digit
    import alarm_pkg::*;
#(
    parameter int MAX = UNITS_MAX
) (
    input  logic       clk4,
    input  logic       reset,
    input  logic       i_load,
    input  logic [3:0] i_load_val,
    input  logic       i_inc,
    input  logic       i_dec,
    output logic [3:0] o_digit
);

    localparam logic [3:0] MAX_V = 4'(MAX);

    logic [3:0] r_digit;

    always_ff @(posedge clk4 or posedge reset) begin
        if (reset) begin
            r_digit <= 4'd0;
        end else if (i_load) begin
            r_digit <= i_load_val;
        end else if (i_inc && !i_dec) begin
            r_digit <= (r_digit >= MAX_V) ? 4'd0 : r_digit + 4'd1;
        end else if (i_dec && !i_inc) begin
            // Out-of-range values (never produced here) fold back to MAX.
            r_digit <= (r_digit == 4'd0 || r_digit > MAX_V) ? MAX_V : r_digit - 4'd1;
        end
    end

    assign o_digit = r_digit;

endmodule

// File: rtl/alarm_bank.sv
// alarm_bank: multi-slot mm:ss alarm unit.
//   NUM_ALARMS stored BCD alarm times, one edited at a time via cursor/inc/dec.
//   Armed slots are compared against cur_time on sec_tick while idle; the
//   lowest matching slot starts a ring that auto-stops after RING_SEC ticks.
//   Optional snooze is built only when ALARM_SNOOZE_EN is defined.
// Ports:
//   clk4, reset                 clock, async active-high reset
//   inc, dec                    digit step pulses (EDIT)
//   move_left, move_right       cursor move pulses (EDIT)
//   enable                      edit level: rise enters, fall commits
//   cancel                      abandon edit
//   slot_next, arm_toggle       slot select / arm flip (IDLE)
//   stop, snooze                silence / defer ring
//   sec_tick, cur_time          timekeeper strobe and BCD time
//   disp_time                   working copy in EDIT, else slot[sel]
//   cursor, blinky              edit cursor (one-hot) and blink code
//   sel, armed                  selected slot, per-slot armed flags
//   ringing, ring_slot          buzzer request and triggering slot
module alarm_bank
    import alarm_pkg::*;
#(
    parameter  int NUM_ALARMS = 4,
    parameter  int RING_SEC   = 30,
    parameter  int SNOOZE_SEC = 60,
    localparam int SLOT_W     = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  clk4,
    input  logic                  reset,
    input  logic                  inc,
    input  logic                  dec,
    input  logic                  move_left,
    input  logic                  move_right,
    input  logic                  enable,
    input  logic                  cancel,
    input  logic                  slot_next,
    input  logic                  arm_toggle,
    input  logic                  stop,
    input  logic                  snooze,
    input  logic                  sec_tick,
    input  logic [15:0]           cur_time,
    output logic [15:0]           disp_time,
    output logic [3:0]            cursor,
    output logic [2:0]            blinky,
    output logic [SLOT_W-1:0]     sel,
    output logic [NUM_ALARMS-1:0] armed,
    output logic                  ringing,
    output logic [SLOT_W-1:0]     ring_slot
);

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_ALARMS - 1);
    localparam logic [7:0]        RING_LAST = 8'(RING_SEC - 1);

    state_t                       r_state;
    logic                         r_en_q;
    logic [NUM_ALARMS-1:0][15:0]  r_slot;
    logic [NUM_ALARMS-1:0]        r_armed;
    logic [SLOT_W-1:0]            r_sel;
    logic [3:0]                   r_cursor;
    logic [2:0]                   r_blinky;
    logic                         r_ringing;
    logic [SLOT_W-1:0]            r_ring_slot;
    logic [7:0]                   r_ring_cnt;
`ifdef ALARM_SNOOZE_EN
    logic [7:0]                   r_snz_cnt;
`else
    logic                         w_unused_snooze;
    assign w_unused_snooze = snooze;
`endif

    logic                         w_rise, w_fall;
    logic [NUM_ALARMS-1:0]        w_hit;
    logic                         w_hit_any;
    logic [SLOT_W-1:0]            w_hit_idx;
    logic                         w_match;
    logic                         w_load;
    logic                         w_edit;
    logic [15:0]                  w_sel_slot;
    logic [15:0]                  w_work;
    logic [3:0]                   w_cur_next;

    assign w_rise     = enable & ~r_en_q;
    assign w_fall     = ~enable & r_en_q;
    assign w_sel_slot = r_slot[r_sel];
    assign w_edit     = (r_state == ST_EDIT);

    // Match comparators; priority encoder below keeps the lowest index.
    for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_cmp
        assign w_hit[i] = r_armed[i] && (r_slot[i] == cur_time);
    end

    always_comb begin
        w_hit_any = 1'b0;
        w_hit_idx = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_hit_any = 1'b1;
                w_hit_idx = SLOT_W'(i);
            end
        end
    end

    // A match in IDLE outranks an enable rise in the same cycle.
    assign w_match = (r_state == ST_IDLE) && sec_tick && w_hit_any;
    assign w_load  = (r_state == ST_IDLE) && w_rise && !w_match;

    // Working copy: digit 3 = MT ... digit 0 = SU; odd digits are tens.
    // inc/dec are steered by the cursor before any same-cycle move lands.
    for (genvar d = 0; d < 4; d++) begin : g_dig
        bcd_wrap_digit #(
            .MAX((d % 2 == 1) ? TENS_MAX : UNITS_MAX)
        ) u_dig (
            .clk4       (clk4),
            .reset      (reset),
            .i_load     (w_load),
            .i_load_val (w_sel_slot[4*d +: 4]),
            .i_inc      (w_edit && inc && r_cursor[d]),
            .i_dec      (w_edit && dec && r_cursor[d]),
            .o_digit    (w_work[4*d +: 4])
        );
    end

    // Right walks MT->SU (shift toward LSB), left walks SU->MT; both wrap.
    always_comb begin
        w_cur_next = r_cursor;
        if (move_right && !move_left)
            w_cur_next = {r_cursor[0], r_cursor[3:1]};
        else if (move_left && !move_right)
            w_cur_next = {r_cursor[2:0], r_cursor[3]};
    end

    always_ff @(posedge clk4 or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_en_q      <= 1'b0;
            r_slot      <= '0;
            r_armed     <= '0;
            r_sel       <= '0;
            r_cursor    <= CUR_NONE;
            r_blinky    <= BLK_NONE;
            r_ringing   <= 1'b0;
            r_ring_slot <= '0;
            r_ring_cnt  <= 8'd0;
`ifdef ALARM_SNOOZE_EN
            r_snz_cnt   <= 8'd0;
`endif
        end else begin
            r_en_q <= enable;
            case (r_state)
                ST_IDLE: begin
                    if (w_match) begin
                        r_state     <= ST_RING;
                        r_ring_slot <= w_hit_idx;
                        r_ring_cnt  <= 8'd0;
                        r_ringing   <= 1'b1;
                    end else if (w_rise) begin
                        r_state  <= ST_EDIT;
                        r_cursor <= CUR_MT;
                        r_blinky <= BLK_MT;
                    end else begin
                        if (slot_next)
                            r_sel <= (r_sel == LAST_SLOT) ? '0 : r_sel + 1'b1;
                        if (arm_toggle)
                            r_armed[r_sel] <= ~r_armed[r_sel];
                    end
                end
                ST_EDIT: begin
                    if (cancel) begin
                        r_state  <= ST_IDLE;
                        r_cursor <= CUR_NONE;
                        r_blinky <= BLK_NONE;
                    end else if (w_fall) begin
                        r_state        <= ST_IDLE;
                        r_slot[r_sel]  <= w_work;
                        r_armed[r_sel] <= 1'b1;
                        r_cursor       <= CUR_NONE;
                        r_blinky       <= BLK_NONE;
                    end else begin
                        r_cursor <= w_cur_next;
                        r_blinky <= blinky_of(w_cur_next);
                    end
                end
                ST_RING: begin
                    if (stop) begin
                        r_state   <= ST_IDLE;
                        r_ringing <= 1'b0;
`ifdef ALARM_SNOOZE_EN
                    end else if (snooze) begin
                        r_state   <= ST_SNOOZE;
                        r_ringing <= 1'b0;
                        r_snz_cnt <= 8'(SNOOZE_SEC);
`endif
                    end else if (sec_tick) begin
                        if (r_ring_cnt == RING_LAST) begin
                            r_state   <= ST_IDLE;
                            r_ringing <= 1'b0;
                        end else begin
                            r_ring_cnt <= r_ring_cnt + 8'd1;
                        end
                    end
                end
`ifdef ALARM_SNOOZE_EN
                ST_SNOOZE: begin
                    if (stop) begin
                        r_state <= ST_IDLE;
                    end else if (sec_tick) begin
                        if (r_snz_cnt == 8'd1) begin
                            r_state    <= ST_RING;
                            r_ringing  <= 1'b1;
                            r_ring_cnt <= 8'd0;
                            r_snz_cnt  <= 8'd0;
                        end else begin
                            r_snz_cnt <= r_snz_cnt - 8'd1;
                        end
                    end
                end
`endif
                default: begin
                    r_state   <= ST_IDLE;
                    r_ringing <= 1'b0;
                end
            endcase
        end
    end

    // Pure select between registers, so it moves on the same edge as state.
    assign disp_time = w_edit ? w_work : w_sel_slot;
    assign cursor    = r_cursor;
    assign blinky    = r_blinky;
    assign sel       = r_sel;
    assign armed     = r_armed;
    assign ringing   = r_ringing;
    assign ring_slot = r_ring_slot;

endmodule

// File: tb/tb_alarm_bank.sv
// tb_alarm_bank: scoreboard bench for alarm_bank (NUM_ALARMS=4, RING_SEC=30,
// SNOOZE_SEC=60). Expected values are queued as stimulus is driven and
// compared #1 after the clock edge that applies it.
module tb_alarm_bank;

    logic        clk4 = 1'b0;
    logic        reset = 1'b1;
    logic        inc = 0, dec = 0, move_left = 0, move_right = 0;
    logic        enable = 0, cancel = 0, slot_next = 0, arm_toggle = 0;
    logic        stop = 0, snooze = 0, sec_tick = 0;
    logic [15:0] cur_time = 16'h0;
    logic [15:0] disp_time;
    logic [3:0]  cursor;
    logic [2:0]  blinky;
    logic [1:0]  sel;
    logic [3:0]  armed;
    logic        ringing;
    logic [1:0]  ring_slot;

    alarm_bank #(.NUM_ALARMS(4), .RING_SEC(30), .SNOOZE_SEC(60)) dut (
        .clk4(clk4), .reset(reset), .inc(inc), .dec(dec),
        .move_left(move_left), .move_right(move_right), .enable(enable),
        .cancel(cancel), .slot_next(slot_next), .arm_toggle(arm_toggle),
        .stop(stop), .snooze(snooze), .sec_tick(sec_tick), .cur_time(cur_time),
        .disp_time(disp_time), .cursor(cursor), .blinky(blinky), .sel(sel),
        .armed(armed), .ringing(ringing), .ring_slot(ring_slot)
    );

    always #5 clk4 = ~clk4;

    typedef enum int {S_DISP, S_CUR, S_BLK, S_SEL, S_ARM, S_RING, S_RSLOT} sig_e;
    typedef struct {
        string       tag;
        sig_e        sig;
        logic [15:0] val;
    } exp_t;

    exp_t        sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] m_slot[4];
    logic [3:0]  m_armed = 4'b0;
    int          m_sel   = 0;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    task automatic push(input string tag, input sig_e s, input logic [15:0] v);
        exp_t e;
        e.tag = tag; e.sig = s; e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic sb_check();
        exp_t        e;
        logic [15:0] act;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.sig)
                S_DISP:  act = disp_time;
                S_CUR:   act = 16'(cursor);
                S_BLK:   act = 16'(blinky);
                S_SEL:   act = 16'(sel);
                S_ARM:   act = 16'(armed);
                S_RING:  act = 16'(ringing);
                default: act = 16'(ring_slot);
            endcase
            chk(e.tag, act, e.val);
        end
    endtask

    // One clock with the currently driven pulses, then drop pulses and score.
    task automatic step();
        @(posedge clk4);
        #1;
        inc = 0; dec = 0; move_left = 0; move_right = 0; cancel = 0;
        slot_next = 0; arm_toggle = 0; stop = 0; snooze = 0; sec_tick = 0;
        sb_check();
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            sec_tick = 1;
            step();
        end
    endtask

    task automatic slot_nx();
        m_sel = (m_sel + 1) % 4;
        push("slot_next_sel", S_SEL, 16'(m_sel));
        slot_next = 1;
        step();
    endtask

    // Edit the selected slot to target using only inc and right moves.
    task automatic edit_slot(input logic [15:0] target);
        int cur, tg, mx, n;
        enable = 1;
        push("edit_enter_cur", S_CUR, 16'h8);
        step();
        for (int d = 3; d >= 0; d--) begin
            mx  = (d % 2 == 1) ? 5 : 9;
            cur = int'((m_slot[m_sel] >> (4 * d)) & 16'hF);
            tg  = int'((target >> (4 * d)) & 16'hF);
            n   = (tg - cur + mx + 1) % (mx + 1);
            repeat (n) begin
                inc = 1;
                step();
            end
            if (d > 0) begin
                move_right = 1;
                step();
            end
        end
        push("edit_work", S_DISP, target);
        sb_check();
        m_slot[m_sel]  = target;
        m_armed[m_sel] = 1'b1;
        enable = 0;
        push("edit_commit_disp", S_DISP, target);
        push("edit_commit_armed", S_ARM, 16'(m_armed));
        step();
    endtask

    initial begin
        for (int i = 0; i < 4; i++) m_slot[i] = 16'h0;
        repeat (2) @(posedge clk4);
        #1 reset = 0;
        push("rst_disp", S_DISP, 16'h0);
        push("rst_armed", S_ARM, 16'h0);
        push("rst_cursor", S_CUR, 16'h0);
        push("rst_blinky", S_BLK, 16'h0);
        push("rst_ringing", S_RING, 16'h0);
        push("rst_sel", S_SEL, 16'h0);
        sb_check();

        // Slot0 -> 5200: dec on MT wraps 0->5, MU incremented 12 times.
        enable = 1;
        push("enter_cursor", S_CUR, 16'h8);
        push("enter_blinky", S_BLK, 16'h1);
        step();
        dec = 1;
        push("mt_dec_wrap", S_DISP, 16'h5000);
        step();
        move_right = 1;
        push("right_cursor", S_CUR, 16'h4);
        push("right_blinky", S_BLK, 16'h2);
        step();
        repeat (12) begin
            inc = 1;
            step();
        end
        push("mu_inc12", S_DISP, 16'h5200);
        sb_check();
        enable = 0;
        m_slot[0] = 16'h5200; m_armed[0] = 1'b1;
        push("commit_disp", S_DISP, 16'h5200);
        push("commit_armed", S_ARM, 16'h1);
        push("commit_cursor", S_CUR, 16'h0);
        push("commit_blinky", S_BLK, 16'h0);
        step();

        // Slot1 edited to 0130 then cancelled.
        slot_nx();
        enable = 1;
        step();
        move_right = 1; step();
        inc = 1; step();
        move_right = 1; step();
        repeat (3) begin
            inc = 1;
            step();
        end
        push("s1_work", S_DISP, 16'h0130);
        sb_check();
        cancel = 1;
        push("cancel_disp", S_DISP, 16'h0000);
        push("cancel_armed", S_ARM, 16'h1);
        push("cancel_cursor", S_CUR, 16'h0);
        step();
        push("held_enable_no_reentry", S_CUR, 16'h0);
        step();
        enable = 0;
        step();

        // Cursor wrap, simultaneous pulses, edit on the old cursor digit.
        enable = 1;
        step();
        move_left = 1;
        push("left_wrap_cursor", S_CUR, 16'h1);
        push("left_wrap_blinky", S_BLK, 16'h4);
        step();
        inc = 1; dec = 1;
        push("incdec_hold", S_DISP, 16'h0000);
        step();
        move_left = 1; move_right = 1;
        push("leftright_hold", S_CUR, 16'h1);
        step();
        inc = 1; move_right = 1;
        push("inc_old_digit", S_DISP, 16'h0001);
        push("right_wrap_cursor", S_CUR, 16'h8);
        step();
        dec = 1;
        push("mt_dec_after_wrap", S_DISP, 16'h5001);
        step();
        slot_next = 1; arm_toggle = 1;
        push("edit_ignores_slot_next", S_SEL, 16'h1);
        push("edit_ignores_arm", S_ARM, 16'h1);
        step();
        cancel = 1;
        push("cancel2_disp", S_DISP, 16'h0000);
        step();
        enable = 0;
        step();

        // Arm toggle both ways, then slot wrap back to 0.
        arm_toggle = 1;
        push("arm_on", S_ARM, 16'h3);
        step();
        arm_toggle = 1;
        push("arm_off", S_ARM, 16'h1);
        step();
        repeat (3) slot_nx();

        // Slot0 and slot2 at 0010.
        edit_slot(16'h0010);
        slot_nx(); slot_nx();
        edit_slot(16'h0010);
        slot_nx(); slot_nx();

        // A match while editing is dropped.
        enable = 1;
        step();
        cur_time = 16'h0010; sec_tick = 1;
        push("edit_match_dropped", S_RING, 16'h0);
        push("edit_match_cursor", S_CUR, 16'h8);
        step();
        cancel = 1; step();
        enable = 0; step();

        // Ring with lowest-slot priority and 30-tick timeout.
        sec_tick = 1;
        push("ring_start", S_RING, 16'h1);
        push("ring_slot_lowest", S_RSLOT, 16'h0);
        step();
        cur_time = 16'h0000;
        ticks(29);
        push("ring_tick29", S_RING, 16'h1);
        sb_check();
        sec_tick = 1;
        push("ring_timeout", S_RING, 16'h0);
        step();

        // Disarm slot0: slot2 now rings; stop wins over snooze.
        arm_toggle = 1;
        push("disarm0", S_ARM, 16'h4);
        step();
        cur_time = 16'h0010; sec_tick = 1;
        push("ring_slot2", S_RING, 16'h1);
        push("ring_slot2_idx", S_RSLOT, 16'h2);
        step();
        cur_time = 16'h0000;
        stop = 1; snooze = 1;
        push("stop_wins", S_RING, 16'h0);
        step();

        // Snooze behaviour depends on the build option.
        cur_time = 16'h0010; sec_tick = 1;
        push("ring_again", S_RING, 16'h1);
        step();
        cur_time = 16'h0000;
        snooze = 1;
`ifdef ALARM_SNOOZE_EN
        push("snooze_silence", S_RING, 16'h0);
        step();
        ticks(59);
        push("snooze_tick59", S_RING, 16'h0);
        sb_check();
        sec_tick = 1;
        push("snooze_rering", S_RING, 16'h1);
        push("snooze_same_slot", S_RSLOT, 16'h2);
        step();
`else
        push("snooze_ignored", S_RING, 16'h1);
        step();
`endif
        stop = 1;
        push("final_stop", S_RING, 16'h0);
        push("final_armed", S_ARM, 16'h4);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
